// File: rtl/bus_sched_pkg.sv
// Shared types and helpers for the round-robin bus scheduler.
//   sched_state_e : scheduler FSM states
//   dest_mask_t   : decoded destination mask plus invalid-ID flag
//   dest_mask()   : destination ID -> receiver mask decode
package bus_sched_pkg;

    localparam int unsigned ID_W       = 8;
    localparam int unsigned MAX_DRVRS  = 32;
    localparam int unsigned MASK_IDX_W = $clog2(MAX_DRVRS);
    localparam logic [ID_W-1:0] BROADCAST = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        POP   = 2'd1,
        ROUTE = 2'd2,
        PUSH  = 2'd3
    } sched_state_e;

    typedef struct packed {
        logic                 invalid;
        logic [MAX_DRVRS-1:0] mask;
    } dest_mask_t;

    // Broadcast targets every driver but the source; an ID beyond the
    // driver count is flagged invalid with an empty mask.
    function automatic dest_mask_t dest_mask(
        input logic [ID_W-1:0] dest,
        input logic [ID_W-1:0] src,
        input int unsigned     drvrs,
        input logic [ID_W-1:0] bcast = BROADCAST
    );
        dest_mask_t r;
        r = '0;
        if (dest == bcast) begin
            for (int unsigned i = 0; i < MAX_DRVRS; i++) begin
                if ((i < drvrs) && (i != 32'(src))) begin
                    r.mask[MASK_IDX_W'(i)] = 1'b1;
                end
            end
        end else if (32'(dest) < drvrs) begin
            for (int unsigned i = 0; i < MAX_DRVRS; i++) begin
                if (i == 32'(dest)) begin
                    r.mask[MASK_IDX_W'(i)] = 1'b1;
                end
            end
        end else begin
            r.invalid = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bus_rr_scheduler_rr_arbiter.sv
// Combinational rotate-priority arbiter.
//   req     : request vector
//   last    : index of the previously served requester
//   gnt     : one-hot grant, first request searching upward from last+1
//   gnt_idx : index of the granted requester (0 when no request)
module rr_arbiter #(
    parameter int unsigned drvrs = 4,
    localparam int unsigned IDX_W = $clog2(drvrs)
) (
    input  logic [drvrs-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [drvrs-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic found;

    // Walk the requesters starting just after last, wrapping modulo drvrs.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int unsigned off = 1; off <= drvrs; off++) begin
            int unsigned cand;
            cand = (32'(last) + off) % drvrs;
            if (!found && req[IDX_W'(cand)]) begin
                found               = 1'b1;
                gnt[IDX_W'(cand)]   = 1'b1;
                gnt_idx             = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/bus_rr_scheduler.sv
// Round-robin scheduler for the shared broadcast bus.
//   clk, reset : clock, asynchronous active-high reset
//   pndng      : source FIFO i non-empty
//   D_pop      : head word of source FIFO i
//   rcv_full   : receiver FIFO i full
//   pop        : one-hot pop of the granted source
//   push       : push strobes into the target receiver(s)
//   D_push     : bus data, valid while any push bit is high
//   grant_id   : index of the last granted source
//   bus_busy   : high whenever the FSM is outside IDLE
//   drop_cnt   : saturating count of dropped packets
module bus_rr_scheduler
    import bus_sched_pkg::*;
#(
    parameter int unsigned    drvrs     = 4,
    parameter int unsigned    pckg_sz   = 16,
    parameter logic [ID_W-1:0] broadcast = BROADCAST,
    parameter int unsigned    timeout   = 16,
    localparam int unsigned   IDX_W     = $clog2(drvrs),
    localparam int unsigned   WAIT_W    = $clog2(timeout + 1)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [drvrs-1:0]                pndng,
    input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
    input  logic [drvrs-1:0]                rcv_full,
    output logic [drvrs-1:0]                pop,
    output logic [drvrs-1:0]                push,
    output logic [pckg_sz-1:0]              D_push,
    output logic [IDX_W-1:0]                grant_id,
    output logic                            bus_busy,
    output logic [15:0]                     drop_cnt
);

    sched_state_e        state_q, state_d;
    logic [IDX_W-1:0]    grant_id_q, grant_id_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [pckg_sz-1:0]  data_q, data_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [15:0]         drop_cnt_q, drop_cnt_d;
    logic [drvrs-1:0]    pop_q, pop_d;
    logic [drvrs-1:0]    push_q, push_d;
    logic [pckg_sz-1:0]  d_push_q, d_push_d;
    logic                bus_busy_q, bus_busy_d;

    logic [drvrs-1:0]    arb_gnt;
    logic [IDX_W-1:0]    arb_idx;
    dest_mask_t          dm;
    logic [drvrs-1:0]    mask;
    logic                blocked;

    rr_arbiter #(.drvrs(drvrs)) u_arb (
        .req     (pndng),
        .last    (last_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    // Destination decode of the latched packet.
    always_comb begin
        dm      = dest_mask(data_q[pckg_sz-1 -: ID_W], ID_W'(grant_id_q), drvrs, broadcast);
        mask    = dm.mask[drvrs-1:0];
        blocked = |(mask & rcv_full);
    end

    if (drvrs < MAX_DRVRS) begin : g_mask_tail
        logic unused_mask_tail;
        assign unused_mask_tail = ^dm.mask[MAX_DRVRS-1:drvrs];
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        last_d     = last_q;
        data_d     = data_q;
        wait_cnt_d = wait_cnt_q;
        drop_cnt_d = drop_cnt_q;
        pop_d      = '0;
        push_d     = '0;
        d_push_d   = d_push_q;

        case (state_q)
            IDLE: begin
                if (|pndng) begin
                    grant_id_d = arb_idx;
                    pop_d      = arb_gnt;
                    state_d    = POP;
                end
            end
            POP: begin
                data_d     = D_pop[grant_id_q];
                wait_cnt_d = '0;
                state_d    = ROUTE;
            end
            ROUTE: begin
                if (dm.invalid || (blocked && (wait_cnt_q == WAIT_W'(timeout - 1)))) begin
                    // Dropping still advances last so this source cannot hog the bus.
                    drop_cnt_d = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1;
                    last_d     = grant_id_q;
                    state_d    = IDLE;
                end else if (!blocked) begin
                    push_d   = mask;
                    d_push_d = data_q;
                    state_d  = PUSH;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            PUSH: begin
                last_d  = grant_id_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        bus_busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            last_q     <= IDX_W'(drvrs - 1);
            data_q     <= '0;
            wait_cnt_q <= '0;
            drop_cnt_q <= '0;
            pop_q      <= '0;
            push_q     <= '0;
            d_push_q   <= '0;
            bus_busy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            last_q     <= last_d;
            data_q     <= data_d;
            wait_cnt_q <= wait_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            pop_q      <= pop_d;
            push_q     <= push_d;
            d_push_q   <= d_push_d;
            bus_busy_q <= bus_busy_d;
        end
    end

    assign pop      = pop_q;
    assign push     = push_q;
    assign D_push   = d_push_q;
    assign grant_id = grant_id_q;
    assign bus_busy = bus_busy_q;
    assign drop_cnt = drop_cnt_q;

endmodule
